result_drain: RTL

RESULT_DRAIN -- requirements
Module: result_drain

---
 rtl/grid_pkg.sv | 15 +
 rtl/result_fifo.sv | 54 +++++
 rtl/result_drain.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/grid_pkg.sv
// Shared grid defaults and result-drain FSM encoding.
// Imported by the drain top and its row FIFO.
package grid_pkg;

  localparam int unsigned DEF_N            = 4;
  localparam int unsigned DEF_DATA_WIDTH   = 16;
  localparam int unsigned DEF_RESULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } drain_state_e;

endpackage

// File: rtl/result_fifo.sv
// Row FIFO for deskewed results; the MSB of each entry is the last-row tag.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module result_fifo #(
  parameter int unsigned WIDTH = 129,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             accept_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign empty_o  = (cnt_q == '0);
  assign full_o   = (cnt_q == CW'(DEPTH));
  assign do_pop   = pop_i && !empty_o;
  assign do_push  = push_i && (!full_o || do_pop);
  assign accept_o = do_push;
  assign count_o  = cnt_q;
  assign rdata_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= AW'(wr_ptr_q + 1'b1);
      if (do_pop)  rd_ptr_q <= AW'(rd_ptr_q + 1'b1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= CW'(cnt_q + 1'b1);
        2'b01:   cnt_q <= CW'(cnt_q - 1'b1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/result_drain.sv
// Deskews systolic bottom sums into whole rows, buffers a tile's rows
// and drains them over a valid/ready port with a last-row marker.
module result_drain
  import grid_pkg::*;
#(
  parameter int unsigned N             = DEF_N,
  parameter int unsigned RESULT_WIDTH  = DEF_RESULT_WIDTH,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned ROW_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [N*RESULT_WIDTH-1:0] sums_bottom,
  input  logic                      sums_valid,
  input  logic                      start,
  input  logic [ROW_CNT_WIDTH-1:0]  tile_rows,
  output logic [N*RESULT_WIDTH-1:0] out_row,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      stall_req,
  output logic                      overflow,
  output logic                      busy
);

  localparam int unsigned RW = N * RESULT_WIDTH;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [RW-1:0] dsk_row;
  logic          dsk_vld;

  // Column j arrives j cycles late, so it gets N-1-j stages to line up.
  for (genvar j = 0; j < N; j++) begin : g_col
    localparam int unsigned D = N - 1 - j;
    if (D == 0) begin : g_pass
      assign dsk_row[j*RESULT_WIDTH +: RESULT_WIDTH] =
        sums_bottom[j*RESULT_WIDTH +: RESULT_WIDTH];
    end else begin : g_sh
      logic [RESULT_WIDTH-1:0] sh_q [D];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < D; k++) sh_q[k] <= '0;
        end else if (enable) begin
          sh_q[0] <= sums_bottom[j*RESULT_WIDTH +: RESULT_WIDTH];
          for (int k = 1; k < D; k++) sh_q[k] <= sh_q[k-1];
        end
      end
      assign dsk_row[j*RESULT_WIDTH +: RESULT_WIDTH] = sh_q[D-1];
    end
  end

  if (N == 1) begin : g_vld_pass
    assign dsk_vld = sums_valid;
  end else begin : g_vld
    logic [N-2:0] vld_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q <= '0;
      end else if (enable) begin
        vld_q[0] <= sums_valid;
        for (int k = 1; k < N - 1; k++) vld_q[k] <= vld_q[k-1];
      end
    end
    assign dsk_vld = vld_q[N-2];
  end

  drain_state_e             state_q, state_d;
  logic [ROW_CNT_WIDTH-1:0] rows_q, rows_d;
  logic [ROW_CNT_WIDTH-1:0] cap_q, cap_d;
  logic [ROW_CNT_WIDTH-1:0] pop_q, pop_d;
  logic                     ovf_q, ovf_d;

  logic          push_req, tag_last, accept;
  logic          f_full, f_empty, pop_fire;
  logic [RW:0]   f_head;
  logic [CW-1:0] f_count;

  assign push_req = (state_q == ST_COLLECT) && dsk_vld && enable;
  assign tag_last = (cap_q == rows_q - ROW_CNT_WIDTH'(1));
  assign pop_fire = !f_empty && out_ready;

  result_fifo #(
    .WIDTH (RW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_i   (push_req),
    .wdata_i  ({tag_last, dsk_row}),
    .pop_i    (out_ready),
    .rdata_o  (f_head),
    .count_o  (f_count),
    .full_o   (f_full),
    .empty_o  (f_empty),
    .accept_o (accept)
  );

  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    cap_d   = cap_q;
    pop_d   = pop_q;
    ovf_d   = ovf_q;
    if (pop_fire) pop_d = pop_q + ROW_CNT_WIDTH'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (start && (tile_rows != '0)) begin
          state_d = ST_COLLECT;
          rows_d  = tile_rows;
          cap_d   = '0;
          pop_d   = '0;
        end
      end
      ST_COLLECT: begin
        if (push_req) begin
          cap_d = cap_q + ROW_CNT_WIDTH'(1);
          if (!accept) ovf_d = 1'b1;
          if (tag_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // An empty FIFO here means the tagged row was dropped.
        if (f_empty || (pop_fire && f_head[RW])) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rows_q  <= '0;
      cap_q   <= '0;
      pop_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      cap_q   <= cap_d;
      pop_q   <= pop_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = !f_empty;
  assign out_row   = f_empty ? '0 : f_head[RW-1:0];
  assign out_last  = !f_empty && f_head[RW];
  assign stall_req = (f_count >= CW'(FIFO_DEPTH - N));
  assign overflow  = ovf_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
